// File: rtl/core_wb.sv
// core_wb -- register file writeback stage.
//
// Merges single-cycle ALU results with asynchronous memory load responses,
// aligns/extends load data, and drives the registered waddr_o/wdata_o pair
// consumed by the register file. Tracks the single outstanding load and flags
// read hazards so decode can stall.
//
// Configuration macro: CORE_WB_SUBWORD_EN
//   defined     -> byte/half load alignment and sign/zero extension
//   not defined -> every load writes the raw memory word (LW behaviour)
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   alu_valid_i/alu_rd_i/alu_data_i ALU result in; alu_ready_o = accepted
//   ld_issue_i/ld_rd_i/ld_funct3_i/ld_addr_lo_i  load issue in
//   ld_busy_o                      a load is outstanding
//   rsp_valid_i/rsp_data_i         memory load response
//   raddr_a_i/raddr_b_i            decode read addresses; hazard_o = stall
//   waddr_o/wdata_o                register file write port (waddr 0 = none)
module core_wb (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    output logic        alu_ready_o,
    input  logic        ld_issue_i,
    input  logic [4:0]  ld_rd_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    output logic        ld_busy_o,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_data_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic        hazard_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        capture;
    logic [4:0]  ld_rd_q;

`ifdef CORE_WB_SUBWORD_EN
    logic [2:0]  ld_funct3_q;
    logic [1:0]  ld_addr_lo_q;

    // Byte shift uses the full address offset; halves only use bit 1 so a
    // misaligned half reads the half containing the addressed byte.
    function automatic logic [31:0] align_load(input logic [31:0] word,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  addr_lo);
        logic [31:0]        sh_b;
        logic [31:0]        sh_h;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [31:0]        res;
        sh_b   = word >> {addr_lo, 3'b000};
        sh_h   = word >> {addr_lo[1], 4'b0000};
        byte_s = sh_b[7:0];
        half_s = sh_h[15:0];
        case (funct3)
            3'b000:  res = 32'(byte_s);
            3'b001:  res = 32'(half_s);
            3'b100:  res = {24'd0, sh_b[7:0]};
            3'b101:  res = {16'd0, sh_h[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction
`else
    logic unused_ld_fields;
    assign unused_ld_fields = ^{ld_funct3_i, ld_addr_lo_i};
`endif

    logic        rsp_take;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic [4:0]  waddr_p1;
    logic [31:0] wdata_p1;

    // Load FSM next state and write-source selection
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        rsp_take    = 1'b0;
        wr_en       = 1'b0;
        wr_rd       = 5'd0;
        wr_data     = 32'd0;
        alu_ready_o = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (ld_issue_i) begin
                    capture = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_valid_i) begin
                    rsp_take = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Load response has priority; the ALU producer holds while stalled.
        if (rsp_take) begin
            alu_ready_o = 1'b0;
            wr_en       = 1'b1;
            wr_rd       = ld_rd_q;
`ifdef CORE_WB_SUBWORD_EN
            wr_data     = align_load(rsp_data_i, ld_funct3_q, ld_addr_lo_q);
`else
            wr_data     = rsp_data_i;
`endif
        end else if (alu_valid_i) begin
            wr_en   = 1'b1;
            wr_rd   = alu_rd_i;
            wr_data = alu_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ld_rd_q <= 5'd0;
        end else begin
            state_q <= state_d;
            if (capture) ld_rd_q <= ld_rd_i;
        end
    end

`ifdef CORE_WB_SUBWORD_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_funct3_q  <= 3'd0;
            ld_addr_lo_q <= 2'd0;
        end else if (capture) begin
            ld_funct3_q  <= ld_funct3_i;
            ld_addr_lo_q <= ld_addr_lo_i;
        end
    end
`endif

    // Stage p1: registered write port, valid for exactly one cycle per accept
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            waddr_p1 <= 5'd0;
            wdata_p1 <= 32'd0;
        end else begin
            waddr_p1 <= wr_en ? wr_rd : 5'd0;
            if (wr_en) wdata_p1 <= wr_data;
        end
    end

    assign waddr_o   = waddr_p1;
    assign wdata_o   = wdata_p1;
    assign ld_busy_o = (state_q == S_WAIT);

    // A zero destination never produces a write, so it cannot hazard.
    assign hazard_o = (ld_busy_o && (ld_rd_q != 5'd0) &&
                       ((raddr_a_i == ld_rd_q) || (raddr_b_i == ld_rd_q))) ||
                      ((waddr_p1 != 5'd0) &&
                       ((raddr_a_i == waddr_p1) || (raddr_b_i == waddr_p1)));

endmodule

// File: tb/tb_core_wb.sv
module tb_core_wb;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_rd_i = '0;
    logic [31:0] alu_data_i = '0;
    logic        alu_ready_o;
    logic        ld_issue_i = 1'b0;
    logic [4:0]  ld_rd_i = '0;
    logic [2:0]  ld_funct3_i = '0;
    logic [1:0]  ld_addr_lo_i = '0;
    logic        ld_busy_o;
    logic        rsp_valid_i = 1'b0;
    logic [31:0] rsp_data_i = '0;
    logic [4:0]  raddr_a_i = '0;
    logic [4:0]  raddr_b_i = '0;
    logic        hazard_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;

    int n_cmp = 0;
    int n_err = 0;

    core_wb dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .alu_valid_i  (alu_valid_i),
        .alu_rd_i     (alu_rd_i),
        .alu_data_i   (alu_data_i),
        .alu_ready_o  (alu_ready_o),
        .ld_issue_i   (ld_issue_i),
        .ld_rd_i      (ld_rd_i),
        .ld_funct3_i  (ld_funct3_i),
        .ld_addr_lo_i (ld_addr_lo_i),
        .ld_busy_o    (ld_busy_o),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_data_i   (rsp_data_i),
        .raddr_a_i    (raddr_a_i),
        .raddr_b_i    (raddr_b_i),
        .hazard_o     (hazard_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issue a load, respond on the following cycle, check the written word.
    task automatic load_chk(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] lo, input logic [31:0] raw,
                            input logic [31:0] exp_sub);
        ld_issue_i = 1'b1; ld_rd_i = rd; ld_funct3_i = f3; ld_addr_lo_i = lo;
        step();
        ld_issue_i = 1'b0;
        rsp_valid_i = 1'b1; rsp_data_i = raw;
        step();
        rsp_valid_i = 1'b0;
        check({tag, "_waddr"}, 32'(waddr_o), 32'(rd));
`ifdef CORE_WB_SUBWORD_EN
        check({tag, "_wdata"}, wdata_o, exp_sub);
`else
        check({tag, "_wdata"}, wdata_o, raw);
`endif
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_waddr", 32'(waddr_o), 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_busy", 32'(ld_busy_o), 32'd0);
        check("rst_hazard", 32'(hazard_o), 32'd0);
        check("rst_ready", 32'(alu_ready_o), 32'd1);
        step();
        rst_ni = 1'b1;
        step();

        // ALU only
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
        step();
        alu_valid_i = 1'b0;
        check("alu_waddr", 32'(waddr_o), 32'd5);
        check("alu_wdata", wdata_o, 32'hDEADBEEF);
        step();
        check("alu_waddr_clr", 32'(waddr_o), 32'd0);

        // Load alignment / extension
        load_chk("lb3",  5'd4, 3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80);
        load_chk("lbu3", 5'd4, 3'b100, 2'd3, 32'h80FF_0000, 32'h0000_0080);
        load_chk("lhu2", 5'd6, 3'b101, 2'd2, 32'h8001_1234, 32'h0000_8001);
        load_chk("lh2",  5'd6, 3'b001, 2'd2, 32'h8001_1234, 32'hFFFF_8001);
        load_chk("lh3",  5'd6, 3'b001, 2'd3, 32'h8001_1234, 32'hFFFF_8001);
        load_chk("lb1",  5'd8, 3'b000, 2'd1, 32'h0000_7F00, 32'h0000_007F);
        load_chk("lw",   5'd8, 3'b010, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D);
        load_chk("f3_7", 5'd8, 3'b111, 2'd1, 32'h1357_9BDF, 32'h1357_9BDF);
        step();

        // Collision: response and ALU in the same cycle
        ld_issue_i = 1'b1; ld_rd_i = 5'd7; ld_funct3_i = 3'b010; ld_addr_lo_i = 2'd0;
        step();
        ld_issue_i = 1'b0;
        rsp_valid_i = 1'b1; rsp_data_i = 32'h0000_0011;
        alu_valid_i = 1'b1; alu_rd_i = 5'd9; alu_data_i = 32'h0000_0022;
        #1;
        check("col_ready0", 32'(alu_ready_o), 32'd0);
        step();
        rsp_valid_i = 1'b0;
        #1;
        check("col_ready1", 32'(alu_ready_o), 32'd1);
        check("col_waddr1", 32'(waddr_o), 32'd7);
        check("col_wdata1", wdata_o, 32'h0000_0011);
        step();
        alu_valid_i = 1'b0;
        check("col_waddr2", 32'(waddr_o), 32'd9);
        check("col_wdata2", wdata_o, 32'h0000_0022);
        step();
        check("col_waddr3", 32'(waddr_o), 32'd0);

        // Hazard: pending load rd=3
        ld_issue_i = 1'b1; ld_rd_i = 5'd3;
        step();
        ld_issue_i = 1'b0;
        raddr_b_i = 5'd3;
        #1;
        check("hz_pend_b", 32'(hazard_o), 32'd1);
        raddr_b_i = 5'd4;
        #1;
        check("hz_pend_other", 32'(hazard_o), 32'd0);
        rsp_valid_i = 1'b1; rsp_data_i = 32'h0000_0033;
        step();
        rsp_valid_i = 1'b0;
        raddr_b_i = 5'd0; raddr_a_i = 5'd3;
        #1;
        check("hz_wb_waddr", 32'(waddr_o), 32'd3);
        check("hz_wb_a", 32'(hazard_o), 32'd1);
        raddr_a_i = 5'd0;
        #1;
        check("hz_wb_zero", 32'(hazard_o), 32'd0);
        step();

        // rd=0 load: no hazard on address 0, no architectural write
        ld_issue_i = 1'b1; ld_rd_i = 5'd0;
        step();
        ld_issue_i = 1'b0;
        #1;
        check("rd0_busy", 32'(ld_busy_o), 32'd1);
        check("rd0_hazard", 32'(hazard_o), 32'd0);
        rsp_valid_i = 1'b1; rsp_data_i = 32'h0000_5555;
        step();
        rsp_valid_i = 1'b0;
        check("rd0_waddr", 32'(waddr_o), 32'd0);
        check("rd0_busy_clr", 32'(ld_busy_o), 32'd0);
        step();

        // Spurious response in IDLE
        rsp_valid_i = 1'b1; rsp_data_i = 32'h0000_1234;
        step();
        rsp_valid_i = 1'b0;
        check("spur_waddr", 32'(waddr_o), 32'd0);
        check("spur_busy", 32'(ld_busy_o), 32'd0);

        // Issue while busy is ignored
        ld_issue_i = 1'b1; ld_rd_i = 5'd10;
        step();
        ld_rd_i = 5'd11;
        step();
        ld_issue_i = 1'b0;
        raddr_a_i = 5'd11;
        #1;
        check("busy_iss_11", 32'(hazard_o), 32'd0);
        raddr_a_i = 5'd10;
        #1;
        check("busy_iss_10", 32'(hazard_o), 32'd1);
        raddr_a_i = 5'd0;
        rsp_valid_i = 1'b1; rsp_data_i = 32'h0000_00AA;
        step();
        rsp_valid_i = 1'b0;
        check("busy_iss_waddr", 32'(waddr_o), 32'd10);
        step();

        // Reset mid-WAIT, late response dropped
        ld_issue_i = 1'b1; ld_rd_i = 5'd12;
        step();
        ld_issue_i = 1'b0;
        check("rmid_busy", 32'(ld_busy_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rmid_busy_rst", 32'(ld_busy_o), 32'd0);
        check("rmid_wdata_rst", wdata_o, 32'd0);
        rst_ni = 1'b1;
        rsp_valid_i = 1'b1; rsp_data_i = 32'h0000_BEEF;
        step();
        rsp_valid_i = 1'b0;
        check("rmid_waddr", 32'(waddr_o), 32'd0);
        check("rmid_busy_after", 32'(ld_busy_o), 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/core_wb.md
# core_wb

Writeback stage feeding the core register file's write port. Merges single-cycle ALU results with asynchronous memory load responses, aligns and extends load data, and drives the registered `waddr`/`wdata` pair the register file consumes. Tracks the single outstanding load destination and raises a read-hazard flag so decode can stall instead of reading a stale register.

## Interface
- Parameters: none.
- `clk_i`  in  1  core clock; all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `alu_valid_i`  in  1  ALU result present this cycle.
- `alu_rd_i`  in  5  ALU destination register.
- `alu_data_i`  in  32  ALU result.
- `alu_ready_o`  out  1  ALU result accepted this cycle.
- `ld_issue_i`  in  1  load issued to memory this cycle.
- `ld_rd_i`  in  5  load destination register.
- `ld_funct3_i`  in  3  RV32I load funct3.
- `ld_addr_lo_i`  in  2  load address bits [1:0].
- `ld_busy_o`  out  1  a load is outstanding.
- `rsp_valid_i`  in  1  memory load response present.
- `rsp_data_i`  in  32  raw 32-bit aligned memory word.
- `raddr_a_i`, `raddr_b_i`  in  5 each  decode read addresses for hazard check.
- `hazard_o`  out  1  decode must stall.
- `waddr_o`  out  5  register file write address; 0 = no write.
- `wdata_o`  out  32  register file write data.

## Operation
- Load FSM, two states: IDLE, WAIT.
  - IDLE: `ld_issue_i`=1 -> capture `ld_rd_i`, `ld_funct3_i`, `ld_addr_lo_i`; go WAIT. `rsp_valid_i` in IDLE is dropped.
  - WAIT: `rsp_valid_i`=1 -> write aligned data to captured rd; go IDLE. `ld_issue_i` in WAIT is ignored (issuer must honour `ld_busy_o`).
- `ld_busy_o` = (state == WAIT), combinational.
- Arbitration: load response wins. `alu_ready_o` = !(state==WAIT && `rsp_valid_i`). ALU result transferred when `alu_valid_i` && `alu_ready_o`; producer holds data while not ready.
- rd = 0 from either source: accepted normally, emits `waddr_o`=0 (no architectural write).
- Load alignment (subword feature on): shift = `addr_lo`*8 for bytes, `addr_lo[1]`*16 for halves (bit 0 ignored). LB 000 sign-extend byte; LH 001 sign-extend half; LW 010 raw; LBU 100 zero-extend byte; LHU 101 zero-extend half; 011/110/111 treated as LW.
- `hazard_o` = (WAIT && captured rd != 0 && (raddr_a_i == rd || raddr_b_i == rd)) || (`waddr_o` != 0 && (raddr_a_i == `waddr_o` || raddr_b_i == `waddr_o`)). Read address 0 never hazards.

## Timing
- Reset: `waddr_o`=0, `wdata_o`=0, state IDLE, captured fields 0; hence `ld_busy_o`=0, `hazard_o`=0, `alu_ready_o`=1.
- `waddr_o`/`wdata_o` registered: source accepted in cycle N appears in cycle N+1 for exactly one cycle; register file commits at end of N+1. No accept in N -> `waddr_o`=0 in N+1.
- Earliest response: cycle after issue. Back-to-back load: issue allowed in the cycle after the response (state IDLE again).
- Response and ALU valid same cycle: load written in N+1, ALU stalled, ALU written in N+2 if still valid.
- Reset asserted mid-load: pending load discarded; its late response arrives in IDLE and is dropped.

## Configuration
- `CORE_WB_SUBWORD_EN` defined: byte/half alignment and extension as above; `ld_funct3_i`/`ld_addr_lo_i` captured and used.
- Not defined: every load writes `rsp_data_i` unmodified (LW behaviour); funct3/addr_lo inputs ignored and not stored.

## Test plan
- ALU only: `alu_valid_i`=1, rd=5, data=0xDEADBEEF -> next cycle `waddr_o`=5, `wdata_o`=0xDEADBEEF, then `waddr_o`=0.
- LB addr_lo=3, rsp 0x80FF_0000 -> `wdata_o`=0xFFFFFF80; LBU same -> 0x00000080; LHU addr_lo=2, rsp 0x8001_1234 -> 0x00008001 (subword on); subword off -> 0x8001_1234 for all.
- Collision: WAIT on rd=7, `rsp_valid_i`=1 and ALU rd=9 same cycle -> `alu_ready_o`=0; cycle+1 `waddr_o`=7; cycle+2 `waddr_o`=9.
- Hazard: load rd=3 pending, `raddr_b_i`=3 -> `hazard_o`=1; `raddr_a_i`=0 with rd=0 load -> `hazard_o`=0; during `waddr_o`=3 cycle, `raddr_a_i`=3 -> `hazard_o`=1.
- Spurious response in IDLE with data 0x1234 -> `waddr_o` stays 0; `ld_issue_i` while busy -> captured rd unchanged.
- Reset mid-WAIT, then response -> dropped, `ld_busy_o`=0, `waddr_o`=0.
